// File: rtl/systolic_pkg.sv
// systolic_pkg: shared sizing constants and FSM state encoding for the systolic sequencer
package systolic_pkg;
  localparam int ARRAY_SIZE = 16;
  localparam int SRAM_ADDR_WIDTH = 10;
  localparam int CYCLE_WIDTH = 9;
  localparam int INDEX_WIDTH = 6;
  localparam int TILE_WIDTH = 8;
  localparam int COMPUTE_CYCLES = 3 * ARRAY_SIZE;
  localparam int RESULT_WORDS = 2 * ARRAY_SIZE;
  typedef enum logic [2:0] {IDLE, LOAD, COMPUTE, DRAIN, FINISH} state_e;
endpackage

// File: rtl/systolic_ctrl_if.sv
// systolic_ctrl_if: command, SRAM-read and datapath signals around the systolic sequencer
interface systolic_ctrl_if;
  import systolic_pkg::*;
  logic start;
  logic clear;
  logic out_ready;
  logic [TILE_WIDTH-1:0] tile_num;
  logic [SRAM_ADDR_WIDTH-1:0] base_addr_w;
  logic [SRAM_ADDR_WIDTH-1:0] base_addr_d;
  logic sram_ren;
  logic [SRAM_ADDR_WIDTH-1:0] sram_raddr_w;
  logic [SRAM_ADDR_WIDTH-1:0] sram_raddr_d;
  logic alu_start;
  logic [CYCLE_WIDTH-1:0] cycle_num;
  logic [INDEX_WIDTH-1:0] matrix_index;
  logic out_valid;
  logic busy;
  logic done;
  modport master (
    output start, clear, out_ready, tile_num, base_addr_w, base_addr_d,
    input sram_ren, sram_raddr_w, sram_raddr_d, alu_start, cycle_num, matrix_index, out_valid, busy, done
  );
  modport slave (
    input start, clear, out_ready, tile_num, base_addr_w, base_addr_d,
    output sram_ren, sram_raddr_w, sram_raddr_d, alu_start, cycle_num, matrix_index, out_valid, busy, done
  );
endinterface

// File: rtl/sram_rd_addr_gen.sv
// sram_rd_addr_gen: weight/data SRAM row pointers, loaded on start and stepped once per read
module sram_rd_addr_gen import systolic_pkg::*; (
  input  logic clk,
  input  logic srstn,
  input  logic clr_i,
  input  logic load_i,
  input  logic inc_i,
  input  logic [SRAM_ADDR_WIDTH-1:0] base_w_i,
  input  logic [SRAM_ADDR_WIDTH-1:0] base_d_i,
  output logic [SRAM_ADDR_WIDTH-1:0] addr_w_o,
  output logic [SRAM_ADDR_WIDTH-1:0] addr_d_o
);
  logic [SRAM_ADDR_WIDTH-1:0] ptr_w_q, ptr_d_q;
  // Pointers wrap naturally at the address width, giving modulo row addressing
  always_ff @(posedge clk or negedge srstn)
    if (!srstn) begin
      ptr_w_q <= '0;
      ptr_d_q <= '0;
    end else if (clr_i) begin
      ptr_w_q <= '0;
      ptr_d_q <= '0;
    end else if (load_i) begin
      ptr_w_q <= base_w_i;
      ptr_d_q <= base_d_i;
    end else if (inc_i) begin
      ptr_w_q <= ptr_w_q + 1'b1;
      ptr_d_q <= ptr_d_q + 1'b1;
    end
  assign addr_w_o = ptr_w_q;
  assign addr_d_o = ptr_d_q;
endmodule

// File: rtl/systolic_ctrl.sv
// systolic_ctrl: tile sequencer driving SRAM prefetch, one compute pass and result drain per tile
module systolic_ctrl import systolic_pkg::*; (
  input logic clk,
  input logic srstn,
  systolic_ctrl_if.slave bus
);
  state_e state_q, state_d;
  logic [CYCLE_WIDTH-1:0] cycle_q, cycle_d;
  logic [INDEX_WIDTH-1:0] index_q, index_d;
  logic [TILE_WIDTH-1:0] tile_cnt_q, tile_cnt_d, tile_num_q, tile_num_d;
  logic ren_q, ren_d, alu_q, alu_d, valid_q, valid_d, busy_q, busy_d, done_q, done_d;
  logic accept, last_word, load;
  assign accept = state_q == DRAIN && bus.out_ready;
  assign last_word = accept && index_q == INDEX_WIDTH'(RESULT_WORDS - 1);
  assign load = state_q == IDLE && bus.start && !bus.clear;
  // Next state plus the registered Moore outputs that belong to that next state
  always_comb begin
    state_d = state_q;
    tile_num_d = tile_num_q;
    tile_cnt_d = tile_cnt_q;
    case (state_q)
      IDLE: if (bus.start) begin
        state_d = bus.tile_num == '0 ? FINISH : LOAD;
        tile_num_d = bus.tile_num;
        tile_cnt_d = '0;
      end
      LOAD: state_d = COMPUTE;
      COMPUTE: state_d = cycle_q == CYCLE_WIDTH'(COMPUTE_CYCLES - 1) ? DRAIN : COMPUTE;
      DRAIN: if (last_word) begin
        tile_cnt_d = tile_cnt_q + 1'b1;
        state_d = tile_cnt_d == tile_num_q ? FINISH : LOAD;
      end
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (bus.clear) begin
      state_d = IDLE;
      tile_num_d = '0;
      tile_cnt_d = '0;
    end
    cycle_d = state_d == COMPUTE && state_q == COMPUTE ? cycle_q + 1'b1 :
              state_d == DRAIN ? cycle_q : '0;
    index_d = state_d == DRAIN && state_q == DRAIN ? index_q + INDEX_WIDTH'(accept) : '0;
    ren_d = state_d == LOAD || (state_d == COMPUTE && cycle_d < CYCLE_WIDTH'(ARRAY_SIZE - 1));
    alu_d = state_d == COMPUTE;
    valid_d = state_d == DRAIN;
    busy_d = state_d != IDLE;
    done_d = state_d == FINISH;
  end
  // State, counters and output registers
  always_ff @(posedge clk or negedge srstn)
    if (!srstn) begin
      state_q <= IDLE;
      cycle_q <= '0;
      index_q <= '0;
      tile_cnt_q <= '0;
      tile_num_q <= '0;
      ren_q <= 1'b0;
      alu_q <= 1'b0;
      valid_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cycle_q <= cycle_d;
      index_q <= index_d;
      tile_cnt_q <= tile_cnt_d;
      tile_num_q <= tile_num_d;
      ren_q <= ren_d;
      alu_q <= alu_d;
      valid_q <= valid_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  sram_rd_addr_gen u_addr (
    .clk(clk),
    .srstn(srstn),
    .clr_i(bus.clear),
    .load_i(load),
    .inc_i(ren_q),
    .base_w_i(bus.base_addr_w),
    .base_d_i(bus.base_addr_d),
    .addr_w_o(bus.sram_raddr_w),
    .addr_d_o(bus.sram_raddr_d)
  );
  assign bus.sram_ren = ren_q;
  assign bus.alu_start = alu_q;
  assign bus.cycle_num = cycle_q;
  assign bus.matrix_index = index_q;
  assign bus.out_valid = valid_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
endmodule
